// File: rtl/vga_fb_arbiter.sv
// Frame-buffer port arbiter: scan-out fetches own the RAM inside the active window,
// queued PPU writes drain through a small FIFO in every blanking slot.
module vga_fb_arbiter #(
  parameter int                H_ACTIVE   = 272,
  parameter int                V_ACTIVE   = 204,
  parameter int                H_MAX      = 341,
  parameter int                V_MAX      = 223,
  parameter int                ADDR_W     = 16,
  parameter int                DATA_W     = 8,
  parameter int                FIFO_DEPTH = 16,
  parameter logic [DATA_W-1:0] BG_PIXEL   = '0
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic [9:0]        DrawX,
  input  logic [9:0]        DrawY,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] pix_data,
  output logic              pix_valid,
  output logic [4:0]        fifo_lvl
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {S_FETCH, S_HBLANK, S_VBLANK} slot_t;

  slot_t             state_reg, state_next;
  logic [9:0]        nx, ny;
  logic              in_range;
  logic [ADDR_W-1:0] fetch_addr;

  logic [ADDR_W-1:0] fifo_addr_mem [FIFO_DEPTH];
  logic [DATA_W-1:0] fifo_data_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  rd_ptr_reg, wr_ptr_reg;
  logic [4:0]        count_reg;
  logic              full, empty, push, pop;

  // The RAM has one cycle of read latency, so every slot decision looks one pixel ahead.
  always_comb begin
    nx = '0;
    ny = '0;
    if (DrawX < 10'(H_MAX)) begin
      nx = DrawX + 10'd1;
      ny = DrawY;
    end else begin
      nx = '0;
      ny = (DrawY == 10'(V_MAX)) ? 10'd0 : DrawY + 10'd1;
    end
  end

  assign in_range   = (DrawX <= 10'(H_MAX)) && (DrawY <= 10'(V_MAX));
  assign fetch_addr = ADDR_W'(ny) * ADDR_W'(H_ACTIVE) + ADDR_W'(nx);

  always_comb begin
    state_next = S_VBLANK;
    if (in_range && (ny < 10'(V_ACTIVE))) begin
      state_next = (nx < 10'(H_ACTIVE)) ? S_FETCH : S_HBLANK;
    end
  end

  assign full     = (count_reg == 5'(FIFO_DEPTH));
  assign empty    = (count_reg == 5'd0);
  assign wr_ready = !Reset && !full;
  assign push     = wr_valid && wr_ready;

  // Single RAM port: a fetch slot never writes; blank slots pop at most one entry.
  always_comb begin
    mem_addr  = '0;
    mem_we    = 1'b0;
    mem_wdata = '0;
    pop       = 1'b0;
    if (state_next == S_FETCH) begin
      mem_addr = fetch_addr;
    end else if (!empty && !Reset) begin
      pop       = 1'b1;
      mem_we    = 1'b1;
      mem_addr  = fifo_addr_mem[rd_ptr_reg];
      mem_wdata = fifo_data_mem[rd_ptr_reg];
    end
  end

  always_ff @(posedge Clk) begin
    if (push) begin
      fifo_addr_mem[wr_ptr_reg] <= wr_addr;
      fifo_data_mem[wr_ptr_reg] <= wr_data;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      rd_ptr_reg <= '0;
      wr_ptr_reg <= '0;
      count_reg  <= '0;
      state_reg  <= S_VBLANK;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      if (pop)  rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      case ({push, pop})
        2'b10:   count_reg <= count_reg + 5'd1;
        2'b01:   count_reg <= count_reg - 5'd1;
        default: count_reg <= count_reg;
      endcase
      state_reg <= state_next;
    end
  end

  // The previous slot tells us whether mem_rdata now carries this pixel.
  assign pix_valid = !Reset && (state_reg == S_FETCH);
  assign pix_data  = pix_valid ? mem_rdata : BG_PIXEL;
  assign fifo_lvl  = count_reg;

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// Bench for vga_fb_arbiter: directed scenarios plus a randomized scan checked against
// a queue-based model of the write FIFO and a behavioural frame-buffer RAM.
module tb_vga_fb_arbiter;
  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic [9:0]  DrawX = '0, DrawY = '0;
  logic        wr_valid = 1'b0;
  logic        wr_ready;
  logic [15:0] wr_addr = '0;
  logic [7:0]  wr_data = '0;
  logic [15:0] mem_addr;
  logic        mem_we;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata = '0;
  logic [7:0]  pix_data;
  logic        pix_valid;
  logic [4:0]  fifo_lvl;

  int n_checks = 0;
  int n_pass   = 0;

  vga_fb_arbiter dut (
    .Clk(Clk), .Reset(Reset), .DrawX(DrawX), .DrawY(DrawY),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .pix_data(pix_data), .pix_valid(pix_valid), .fifo_lvl(fifo_lvl)
  );

  always #5 Clk = ~Clk;

  // Frame-buffer RAM with one-cycle read latency; preload port used by the bench only.
  bit   [7:0]  ram [65536];
  logic        pl_en = 1'b0;
  logic [15:0] pl_addr = '0;
  logic [7:0]  pl_data = '0;
  always @(posedge Clk) begin
    if (mem_we) ram[mem_addr] <= mem_wdata;
    else if (pl_en) ram[pl_addr] <= pl_data;
    mem_rdata <= ram[mem_addr];
  end

  // Reference model: slot decided from the look-ahead position, writes kept in a queue.
  typedef struct packed {logic [15:0] a; logic [7:0] d;} wr_t;
  wr_t         mq[$];
  bit          m_prev_fetch = 1'b0;
  logic [15:0] m_prev_addr = '0;

  function automatic void m_slot(input logic [9:0] x, input logic [9:0] y,
                                 output bit fetch, output logic [15:0] addr);
    int nx, ny;
    fetch = 1'b0;
    addr  = '0;
    if (x > 341 || y > 223) return;
    if (x < 341) begin nx = x + 1; ny = y; end
    else begin nx = 0; ny = (y == 223) ? 0 : y + 1; end
    fetch = (nx < 272) && (ny < 204);
    addr  = 16'(ny * 272 + nx);
  endfunction

  always @(posedge Clk) begin
    bit          f;
    logic [15:0] a;
    bit          can_push;
    m_slot(DrawX, DrawY, f, a);
    if (Reset) begin
      mq.delete();
      m_prev_fetch = 1'b0;
      m_prev_addr  = '0;
    end else begin
      can_push = (mq.size() < 16);
      if (!f && mq.size() > 0) void'(mq.pop_front());
      if (wr_valid && can_push) mq.push_back({wr_addr, wr_data});
      m_prev_fetch = f;
      m_prev_addr  = a;
    end
  end

  task automatic drive(input logic r, input int x, input int y, input logic v,
                       input logic [15:0] a, input logic [7:0] d);
    @(posedge Clk); #1;
    Reset = r; DrawX = 10'(x); DrawY = 10'(y);
    wr_valid = v; wr_addr = a; wr_data = d;
    @(negedge Clk);
  endtask

  task automatic test_reset();
    pl_en = 1'b1; pl_addr = 16'd0; pl_data = 8'h2A;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 300, 210, 1'b1, 16'd7, 8'h07);
      n_checks++; if (wr_ready !== 1'b0) $display("FAIL reset_ready got=%0b exp=0", wr_ready); else n_pass++;
      n_checks++; if (mem_we !== 1'b0) $display("FAIL reset_we got=%0b exp=0", mem_we); else n_pass++;
      n_checks++; if (pix_valid !== 1'b0) $display("FAIL reset_pixv got=%0b exp=0", pix_valid); else n_pass++;
    end
    pl_en = 1'b0;
    drive(1'b0, 300, 210, 1'b0, 16'd0, 8'h00);
    n_checks++; if (wr_ready !== 1'b1) $display("FAIL post_reset_ready got=%0b exp=1", wr_ready); else n_pass++;
    n_checks++; if (mem_we !== 1'b0) $display("FAIL post_reset_we got=%0b exp=0", mem_we); else n_pass++;
    n_checks++; if (pix_valid !== 1'b0) $display("FAIL post_reset_pixv got=%0b exp=0", pix_valid); else n_pass++;
    n_checks++; if (pix_data !== 8'h00) $display("FAIL post_reset_pix got=%h exp=00", pix_data); else n_pass++;
    n_checks++; if (fifo_lvl !== 5'd0) $display("FAIL post_reset_lvl got=%0d exp=0", fifo_lvl); else n_pass++;
    $display("xact reset released");
  endtask

  task automatic test_first_fetch();
    drive(1'b0, 341, 223, 1'b0, 16'd0, 8'h00);
    n_checks++; if (mem_addr !== 16'd0) $display("FAIL wrap_addr got=%0d exp=0", mem_addr); else n_pass++;
    n_checks++; if (mem_we !== 1'b0) $display("FAIL wrap_we got=%0b exp=0", mem_we); else n_pass++;
    drive(1'b0, 0, 0, 1'b0, 16'd0, 8'h00);
    n_checks++; if (pix_data !== 8'h2A) $display("FAIL first_pix got=%h exp=2a", pix_data); else n_pass++;
    n_checks++; if (pix_valid !== 1'b1) $display("FAIL first_pixv got=%0b exp=1", pix_valid); else n_pass++;
    $display("xact fetch (0,0) pix=%h", pix_data);
  endtask

  task automatic test_hblank_drain();
    logic [15:0] adr [3];
    logic [7:0]  dat [3];
    adr[0] = 16'd100; adr[1] = 16'd101; adr[2] = 16'd102;
    dat[0] = 8'h11;   dat[1] = 8'h22;   dat[2] = 8'h33;
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 10 + i, 5, 1'b1, adr[i], dat[i]);
      $display("xact push addr=%0d data=%h", adr[i], dat[i]);
    end
    for (int x = 13; x <= 280; x++) begin
      drive(1'b0, x, 5, 1'b0, 16'd0, 8'h00);
      if (x < 271) begin
        n_checks++; if (mem_we !== 1'b0) $display("FAIL early_we x=%0d got=%0b exp=0", x, mem_we); else n_pass++;
      end else if (x <= 273) begin
        n_checks++; if (mem_we !== 1'b1) $display("FAIL drain_we x=%0d got=%0b exp=1", x, mem_we); else n_pass++;
        n_checks++; if (mem_addr !== adr[x-271]) $display("FAIL drain_addr x=%0d got=%0d exp=%0d", x, mem_addr, adr[x-271]); else n_pass++;
        n_checks++; if (mem_wdata !== dat[x-271]) $display("FAIL drain_data x=%0d got=%h exp=%h", x, mem_wdata, dat[x-271]); else n_pass++;
      end else begin
        n_checks++; if (mem_we !== 1'b0) $display("FAIL idle_we x=%0d got=%0b exp=0", x, mem_we); else n_pass++;
      end
      if (x == 271) begin
        n_checks++; if (fifo_lvl !== 5'd3) $display("FAIL lvl_before got=%0d exp=3", fifo_lvl); else n_pass++;
        n_checks++; if (pix_valid !== 1'b1) $display("FAIL last_active_pixv got=%0b exp=1", pix_valid); else n_pass++;
      end
      if (x == 272) begin
        n_checks++; if (pix_valid !== 1'b0) $display("FAIL hblank_pixv got=%0b exp=0", pix_valid); else n_pass++;
      end
      if (x == 274) begin
        n_checks++; if (fifo_lvl !== 5'd0) $display("FAIL lvl_after got=%0d exp=0", fifo_lvl); else n_pass++;
      end
    end
  endtask

  task automatic test_fifo_full();
    bit accepted = 1'b0;
    int acc_x = -1;
    int npop = 0;
    for (int i = 0; i < 16; i++) begin
      drive(1'b0, i, 5, 1'b1, 16'(1000 + i), 8'(i + 1));
      n_checks++; if (wr_ready !== 1'b1) $display("FAIL fill_ready i=%0d got=%0b exp=1", i, wr_ready); else n_pass++;
    end
    for (int x = 16; x <= 340; x++) begin
      drive(1'b0, x, 5, !accepted, 16'd1016, 8'd17);
      if (x == 16) begin
        n_checks++; if (wr_ready !== 1'b0) $display("FAIL full_ready got=%0b exp=0", wr_ready); else n_pass++;
        n_checks++; if (fifo_lvl !== 5'd16) $display("FAIL full_lvl got=%0d exp=16", fifo_lvl); else n_pass++;
      end
      if (mem_we === 1'b1) begin
        n_checks++; if (mem_addr !== 16'(1000 + npop)) $display("FAIL order_addr n=%0d got=%0d exp=%0d", npop, mem_addr, 1000 + npop); else n_pass++;
        n_checks++; if (mem_wdata !== 8'(npop + 1)) $display("FAIL order_data n=%0d got=%0d exp=%0d", npop, mem_wdata, npop + 1); else n_pass++;
        npop++;
      end
      if (!accepted && wr_ready === 1'b1) begin
        accepted = 1'b1;
        acc_x = x;
        $display("xact held write accepted at x=%0d", x);
      end
    end
    n_checks++; if (acc_x != 272) $display("FAIL held_accept_x got=%0d exp=272", acc_x); else n_pass++;
    n_checks++; if (npop != 17) $display("FAIL pop_count got=%0d exp=17", npop); else n_pass++;
    n_checks++; if (fifo_lvl !== 5'd0) $display("FAIL full_drained got=%0d exp=0", fifo_lvl); else n_pass++;
  endtask

  task automatic test_vblank();
    drive(1'b0, 200, 203, 1'b1, 16'd500, 8'h55);
    drive(1'b0, 201, 203, 1'b1, 16'd501, 8'h66);
    drive(1'b0, 341, 203, 1'b0, 16'd0, 8'h00);
    n_checks++; if (mem_we !== 1'b1) $display("FAIL vb_we0 got=%0b exp=1", mem_we); else n_pass++;
    n_checks++; if (mem_addr !== 16'd500) $display("FAIL vb_addr0 got=%0d exp=500", mem_addr); else n_pass++;
    n_checks++; if (mem_wdata !== 8'h55) $display("FAIL vb_data0 got=%h exp=55", mem_wdata); else n_pass++;
    drive(1'b0, 0, 204, 1'b0, 16'd0, 8'h00);
    n_checks++; if (pix_valid !== 1'b0) $display("FAIL vb_pixv got=%0b exp=0", pix_valid); else n_pass++;
    n_checks++; if (pix_data !== 8'h00) $display("FAIL vb_pix got=%h exp=00", pix_data); else n_pass++;
    n_checks++; if (mem_addr !== 16'd501) $display("FAIL vb_addr1 got=%0d exp=501", mem_addr); else n_pass++;
    drive(1'b0, 1, 204, 1'b0, 16'd0, 8'h00);
    n_checks++; if (mem_we !== 1'b0) $display("FAIL vb_idle_we got=%0b exp=0", mem_we); else n_pass++;
    n_checks++; if (fifo_lvl !== 5'd0) $display("FAIL vb_lvl got=%0d exp=0", fifo_lvl); else n_pass++;
    $display("xact vblank drain done");
  endtask

  task automatic test_reset_mid_drain();
    for (int x = 100; x <= 274; x++) begin
      bit v;
      v = (x <= 107) || (x >= 271);
      drive(1'b0, x, 5, v, 16'(2000 + x), 8'(x));
    end
    drive(1'b1, 275, 5, 1'b0, 16'd0, 8'h00);
    n_checks++; if (fifo_lvl !== 5'd8) $display("FAIL mid_lvl got=%0d exp=8", fifo_lvl); else n_pass++;
    n_checks++; if (mem_we !== 1'b0) $display("FAIL mid_reset_we got=%0b exp=0", mem_we); else n_pass++;
    n_checks++; if (wr_ready !== 1'b0) $display("FAIL mid_reset_ready got=%0b exp=0", wr_ready); else n_pass++;
    drive(1'b1, 276, 5, 1'b0, 16'd0, 8'h00);
    n_checks++; if (fifo_lvl !== 5'd0) $display("FAIL mid_cleared got=%0d exp=0", fifo_lvl); else n_pass++;
    drive(1'b0, 277, 5, 1'b0, 16'd0, 8'h00);
    n_checks++; if (mem_we !== 1'b0) $display("FAIL mid_after_we got=%0b exp=0", mem_we); else n_pass++;
    n_checks++; if (wr_ready !== 1'b1) $display("FAIL mid_after_ready got=%0b exp=1", wr_ready); else n_pass++;
    $display("xact reset during drain");
  endtask

  task automatic test_random_scan();
    int x = 0, y = 198;
    for (int c = 0; c < 36 * 342; c++) begin
      bit          f;
      logic [15:0] a;
      bit          exp_we;
      logic [7:0]  exp_pix;
      int          dx;
      dx = (c % 997 == 500) ? 500 : x;
      drive(1'b0, dx, y, ($urandom_range(0, 9) < 7), 16'($urandom_range(0, 2991)), 8'($urandom));
      m_slot(DrawX, DrawY, f, a);
      exp_we  = !f && (mq.size() > 0);
      exp_pix = m_prev_fetch ? ram[m_prev_addr] : 8'h00;
      n_checks++; if (wr_ready !== (mq.size() < 16)) $display("FAIL rnd_ready c=%0d got=%0b lvl=%0d", c, wr_ready, mq.size()); else n_pass++;
      n_checks++; if (mem_we !== exp_we) $display("FAIL rnd_we c=%0d got=%0b exp=%0b", c, mem_we, exp_we); else n_pass++;
      n_checks++; if (fifo_lvl !== 5'(mq.size())) $display("FAIL rnd_lvl c=%0d got=%0d exp=%0d", c, fifo_lvl, mq.size()); else n_pass++;
      n_checks++; if (pix_valid !== m_prev_fetch) $display("FAIL rnd_pixv c=%0d got=%0b exp=%0b", c, pix_valid, m_prev_fetch); else n_pass++;
      n_checks++; if (pix_data !== exp_pix) $display("FAIL rnd_pix c=%0d got=%h exp=%h", c, pix_data, exp_pix); else n_pass++;
      if (f) begin
        n_checks++; if (mem_addr !== a) $display("FAIL rnd_fetch_addr c=%0d got=%0d exp=%0d", c, mem_addr, a); else n_pass++;
      end else if (exp_we) begin
        n_checks++; if (mem_addr !== mq[0].a) $display("FAIL rnd_wr_addr c=%0d got=%0d exp=%0d", c, mem_addr, mq[0].a); else n_pass++;
        n_checks++; if (mem_wdata !== mq[0].d) $display("FAIL rnd_wr_data c=%0d got=%h exp=%h", c, mem_wdata, mq[0].d); else n_pass++;
      end
      if (x == 341) begin
        x = 0;
        y = (y == 223) ? 0 : y + 1;
      end else begin
        x++;
      end
    end
    $display("xact random scan complete");
  endtask

  initial begin
    test_reset();
    test_first_fetch();
    test_hblank_drain();
    test_fifo_full();
    test_vblank();
    test_reset_mid_drain();
    test_random_scan();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
